// File: rtl/rf_write_queue_if.sv
// Request-side handshake bundle for rf_write_queue.
// master: the write producer. slave: the queue.
interface rf_write_queue_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;

  modport master (output req_valid, output req_addr, output req_data, input req_ready);
  modport slave  (input req_valid, input req_addr, input req_data, output req_ready);
endinterface

// File: rtl/rf_write_queue.sv
// rf_write_queue: in-order write-request buffer in front of a register file
// write port. Requests enter over a valid/ready handshake, and one queued entry
// per cycle drains into a registered write stage (rf_we/rf_waddr/rf_wdata).
// Optional feature macro: RF_WQ_BYPASS_EN enables the read-bypass lookup
// (byp_hit/byp_data). Without it, both bypass outputs are tied to zero.
module rf_write_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  rf_write_queue_if.slave   req,
  input  logic              rf_hold,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  input  logic [ADDR_W-1:0] byp_addr,
  output logic              byp_hit,
  output logic [DATA_W-1:0] byp_data
);

  localparam int PTR_W = $clog2(DEPTH);

  // Entry storage. Validity is tracked only by the pointers and count, so the
  // storage itself needs no reset.
  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [DATA_W-1:0] data_mem_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  logic push;
  logic pop;

  // Full/empty come from the count alone; ready never looks at req_valid or
  // rf_hold, so a full queue refuses a push even while it is popping.
  assign empty         = (count_q == '0);
  assign full          = (count_q == CNT_W'(DEPTH));
  assign req.req_ready = !full;

  assign push = req.req_valid && !full;
  assign pop  = !empty && !rf_hold;

  assign count    = count_q;
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  // Next-state: pointer advance, occupancy update and output-stage load.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      rf_we_d    = 1'b1;
      rf_waddr_d = addr_mem_q[rd_ptr_q];
      rf_wdata_d = data_mem_q[rd_ptr_q];
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control and output-stage registers; reset discards everything pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // Capture an accepted request at the tail slot.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem_q[wr_ptr_q] <= req.req_addr;
      data_mem_q[wr_ptr_q] <= req.req_data;
    end
  end

`ifdef RF_WQ_BYPASS_EN
  // Per-position match: position gi counts from the head (oldest) entry.
  logic [DEPTH-1:0]  slot_hit;
  logic [PTR_W-1:0]  slot_idx [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    assign slot_idx[gi] = rd_ptr_q + PTR_W'(gi);
    assign slot_hit[gi] = (CNT_W'(gi) < count_q) && (addr_mem_q[slot_idx[gi]] == byp_addr);
  end

  // Newest match wins: start from the output stage, then let each younger
  // queued entry override the older result.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    if (rf_we_q && (rf_waddr_q == byp_addr)) begin
      byp_hit  = 1'b1;
      byp_data = rf_wdata_q;
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (slot_hit[k]) begin
        byp_hit  = 1'b1;
        byp_data = data_mem_q[slot_idx[k]];
      end
    end
  end
`else
  // Lookup disabled: outputs are constant and the address is deliberately unused.
  logic byp_addr_unused;
  assign byp_addr_unused = ^byp_addr;
  assign byp_hit         = 1'b0;
  assign byp_data        = '0;
`endif

endmodule

// File: tb/tb_rf_write_queue.sv
// Self-checking bench for rf_write_queue: a negedge monitor keeps an
// occupancy model and a scoreboard of accepted writes, and checks every
// rf_we pulse against the scoreboard head in order.
module tb_rf_write_queue;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;
`ifdef RF_WQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic              rf_hold;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic [ADDR_W-1:0] byp_addr;
  logic              byp_hit;
  logic [DATA_W-1:0] byp_data;

  rf_write_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) req_if ();

  rf_write_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req_if.slave),
    .rf_hold  (rf_hold),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .byp_addr (byp_addr),
    .byp_hit  (byp_hit),
    .byp_data (byp_data)
  );

  always #5 clk = ~clk;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int pop_cnt   = 0;
  int mcount    = 0;
  logic [ADDR_W+DATA_W-1:0] sb [$];

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    check_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: inputs are stable at the negedge, so this sees exactly what the
  // next rising edge will act on.
  always @(negedge clk) begin
    logic acc;
    logic pp;
    logic [ADDR_W+DATA_W-1:0] e;
    if (!reset_n) begin
      sb.delete();
      mcount = 0;
    end else begin
      check_value("count", 64'(count), 64'(mcount));
      check_value("req_ready", 64'(req_if.req_ready), 64'(mcount != DEPTH));
      check_value("empty", 64'(empty), 64'(mcount == 0));
      check_value("full", 64'(full), 64'(mcount == DEPTH));
      if (rf_we) begin
        if (sb.size() == 0) begin
          check_value("rf_we_unexpected", 64'(1), 64'(0));
        end else begin
          e = sb.pop_front();
          pop_cnt++;
          check_value("rf_waddr", 64'(rf_waddr), 64'(e[ADDR_W+DATA_W-1:DATA_W]));
          check_value("rf_wdata", 64'(rf_wdata), 64'(e[DATA_W-1:0]));
        end
      end
      acc = req_if.req_valid && (mcount < DEPTH);
      pp  = (mcount != 0) && !rf_hold;
      if (acc) sb.push_back({req_if.req_addr, req_if.req_data});
      mcount = mcount + int'(acc) - int'(pp);
    end
  end

  task automatic set_req(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    req_if.req_valid = v;
    req_if.req_addr  = a;
    req_if.req_data  = d;
  endtask

  task automatic byp_check(input logic [ADDR_W-1:0] a, input logic h, input logic [DATA_W-1:0] d, input string tag);
    byp_addr = a;
    #1;
    check_value({tag, "_hit"}, 64'(byp_hit), 64'(BYP ? h : 1'b0));
    check_value({tag, "_data"}, 64'(byp_data), 64'(BYP ? d : '0));
  endtask

  initial begin
    int sent;
    int guard;
    int pop_start;
    logic acc;

    reset_n  = 1'b0;
    rf_hold  = 1'b0;
    byp_addr = '0;
    set_req(1'b0, '0, '0);
    #12;
    check_value("rst_rf_we", 64'(rf_we), 64'(0));
    check_value("rst_count", 64'(count), 64'(0));
    check_value("rst_empty", 64'(empty), 64'(1));
    check_value("rst_full", 64'(full), 64'(0));
    check_value("rst_waddr", 64'(rf_waddr), 64'(0));
    tick();
    reset_n = 1'b1;
    tick();

    // Single write: visible on rf_* only after the second edge.
    set_req(1'b1, 3'd5, 32'hA5A5_A5A5);
    tick();
    set_req(1'b0, '0, '0);
    check_value("lat_edge1_we", 64'(rf_we), 64'(0));
    check_value("lat_edge1_count", 64'(count), 64'(1));
    tick();
    check_value("lat_edge2_we", 64'(rf_we), 64'(1));
    check_value("lat_edge2_addr", 64'(rf_waddr), 64'(5));
    check_value("lat_edge2_data", 64'(rf_wdata), 64'hA5A5_A5A5);
    tick();
    check_value("lat_pulse_end", 64'(rf_we), 64'(0));
    check_value("lat_hold_addr", 64'(rf_waddr), 64'(5));

    // Fill while held, refuse a fifth request, then drain in order.
    rf_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, ADDR_W'(i + 1), 32'h100 + 32'(i));
      tick();
    end
    set_req(1'b1, 3'd7, 32'hDEAD);
    check_value("fill_full", 64'(full), 64'(1));
    check_value("fill_ready", 64'(req_if.req_ready), 64'(0));
    tick();
    check_value("fill_refuse_count", 64'(count), 64'(4));
    set_req(1'b0, '0, '0);
    rf_hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_value("drain_count", 64'(count), 64'(3 - i));
      check_value("drain_we", 64'(rf_we), 64'(1));
    end
    tick();

    // Streaming: one write in and one out per cycle.
    for (int i = 0; i < 8; i++) begin
      set_req(1'b1, ADDR_W'(i), $urandom);
      tick();
      check_value("stream_count", 64'(count), 64'(1));
      if (i > 0) check_value("stream_we", 64'(rf_we), 64'(1));
    end
    set_req(1'b0, '0, '0);
    tick();
    tick();

    // Wrap: ten entries with random hold-off.
    pop_start = pop_cnt;
    sent  = 0;
    guard = 0;
    while (sent < 10 && guard < 200) begin
      set_req(1'b1, sent[ADDR_W-1:0], 32'(sent));
      rf_hold = 1'($urandom_range(0, 1));
      acc = (mcount < DEPTH);
      tick();
      if (acc) sent++;
      guard++;
    end
    check_value("wrap_sent", 64'(sent), 64'(10));
    set_req(1'b0, '0, '0);
    rf_hold = 1'b0;
    guard = 0;
    while ((sb.size() != 0 || rf_we) && guard < 20) begin
      tick();
      guard++;
    end
    tick();
    check_value("wrap_sb_empty", 64'(sb.size()), 64'(0));
    check_value("wrap_pops", 64'(pop_cnt - pop_start), 64'(10));

    // Bypass lookup: newest queued entry wins, queue beats output stage.
    rf_hold = 1'b1;
    set_req(1'b1, 3'd2, 32'h11);
    tick();
    set_req(1'b1, 3'd2, 32'h22);
    tick();
    set_req(1'b1, 3'd4, 32'h44);
    tick();
    set_req(1'b0, '0, '0);
    byp_check(3'd2, 1'b1, 32'h22, "byp_newest");
    byp_check(3'd3, 1'b0, 32'h0, "byp_miss");
    rf_hold = 1'b0;
    tick();
    rf_hold = 1'b1;
    byp_check(3'd2, 1'b1, 32'h22, "byp_queue_over_rf");
    rf_hold = 1'b0;
    tick();
    byp_check(3'd2, 1'b1, 32'h22, "byp_rf_stage");
    tick();
    byp_check(3'd2, 1'b0, 32'h0, "byp_gone");
    tick();
    byp_check(3'd4, 1'b0, 32'h0, "byp_we_low");

    // Reset mid-drain with three entries still queued.
    rf_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, ADDR_W'(i), 32'h200 + 32'(i));
      tick();
    end
    set_req(1'b0, '0, '0);
    rf_hold = 1'b0;
    tick();
    check_value("mid_count", 64'(count), 64'(3));
    check_value("mid_we", 64'(rf_we), 64'(1));
    reset_n = 1'b0;
    #1;
    check_value("arst_we", 64'(rf_we), 64'(0));
    check_value("arst_count", 64'(count), 64'(0));
    check_value("arst_empty", 64'(empty), 64'(1));
    check_value("arst_waddr", 64'(rf_waddr), 64'(0));
    check_value("arst_wdata", 64'(rf_wdata), 64'(0));
    tick();
    reset_n = 1'b1;
    tick();
    check_value("post_rst_we", 64'(rf_we), 64'(0));
    check_value("post_rst_count", 64'(count), 64'(0));
    tick();

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
